// File: rtl/apb_cmd_pkg.sv
// rtl/apb_cmd_pkg.sv - shared state encoding and watchdog width for apb_cmd_master
package apb_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam int TMO_CNT_W = 16;

endpackage

// File: rtl/apb_cmd_wdog.sv
// rtl/apb_cmd_wdog.sv - hung-slave counter; expire flags the last ACCESS cycle before abort
module apb_cmd_wdog
  import apb_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic pclk,
  input  logic presetn,
  input  logic start,
  input  logic busy,
  input  logic pready,
  output logic expire
);

  localparam logic [TMO_CNT_W-1:0] LIMIT = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_CNT_W-1:0] cnt;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (busy && !pready) begin
      cnt <= cnt + TMO_CNT_W'(1);
    end
  end

  assign expire = busy & ~pready & (cnt == LIMIT);

endmodule

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - valid/ready command stream to single APB4 transfers
// Optional hung-slave watchdog: APB_CMD_MASTER_TIMEOUT_EN
`ifndef P_ADDR_W
`define P_ADDR_W 32
`endif
`ifndef P_DATA_W
`define P_DATA_W 32
`endif
`ifndef P_STRB_W
`define P_STRB_W (DATA_W/8)
`endif

module apb_cmd_master
  import apb_cmd_pkg::*;
#(
  parameter int ADDR_W         = `P_ADDR_W,
  parameter int DATA_W         = `P_DATA_W,
  parameter int STRB_W         = `P_STRB_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  output logic [STRB_W-1:0] pstrb,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pslverr
);

  state_t state, state_nxt;
  logic   ready_en;
  logic   accept;
  logic   expire;
  logic   finish;
  logic   unused_addr_lsb;

  // Holds cmd_ready low until the first edge after reset release.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  assign cmd_ready = ready_en & ((state == ST_IDLE) | ((state == ST_RESP) & rsp_ready));
  assign accept    = cmd_valid & cmd_ready;
  assign finish    = (state == ST_ACCESS) & (pready | expire);

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  apb_cmd_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .pclk    (pclk),
    .presetn (presetn),
    .start   (state == ST_SETUP),
    .busy    (state == ST_ACCESS),
    .pready  (pready),
    .expire  (expire)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)    rsp_timeout <= 1'b0;
    else if (finish) rsp_timeout <= ~pready;
  end
`else
  logic unused_timeout_cfg;

  assign expire             = 1'b0;
  assign rsp_timeout        = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  assign unused_addr_lsb = ^cmd_addr[1:0];

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: if (finish) state_nxt = ST_RESP;
      ST_RESP: begin
        if (accept)         state_nxt = ST_SETUP;
        else if (rsp_ready) state_nxt = ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // APB strobes come straight from the next state so every bus output is a flop.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      pstrb     <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        paddr  <= {cmd_addr[ADDR_W-1:2], 2'b00};
        pwrite <= cmd_write;
        pwdata <= cmd_wdata;
        pstrb  <= cmd_write ? cmd_wstrb : '0;
      end
      psel    <= (state_nxt == ST_SETUP) | (state_nxt == ST_ACCESS);
      penable <= (state_nxt == ST_ACCESS);
      if (finish) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= (pready && !pwrite) ? prdata : '0;
        rsp_err   <= pready ? pslverr : 1'b1;
      end else if ((state == ST_RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - directed self-checking bench for apb_cmd_master
module tb_apb_cmd_master;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int checks = 0;
  int errors = 0;

  apb_cmd_master #(
    .ADDR_W(32), .DATA_W(32), .STRB_W(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Presents one command for a single edge; caller guarantees cmd_ready is high.
  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1; cmd_addr = a; cmd_write = w; cmd_wdata = d; cmd_wstrb = s;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    presetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    repeat (3) step();
    checks++; if ({psel, penable, pwrite, paddr, pwdata, pstrb} !== '0) begin
      errors++; $display("FAIL rst_apb got=%0h exp=0", {psel, penable, pwrite, paddr, pwdata, pstrb}); end
    checks++; if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== '0) begin
      errors++; $display("FAIL rst_rsp got=%0h exp=0", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}); end
    checks++; if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL rst_cmd_ready got=%0b exp=0", cmd_ready); end
    presetn = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL rel_cmd_ready_early got=%0b exp=0", cmd_ready); end
    step();
    checks++; if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rel_cmd_ready got=%0b exp=1", cmd_ready); end
  endtask

  task automatic test_zero_wait_read();
    pready = 1'b1; prdata = 32'hA5A5_1234; pslverr = 1'b0; rsp_ready = 1'b1;
    issue(32'h1000_0007, 1'b0, 32'hFFFF_FFFF, 4'hF);
    checks++; if ({psel, penable} !== 2'b10) begin
      errors++; $display("FAIL zr_setup got=%b exp=10", {psel, penable}); end
    checks++; if (paddr !== 32'h1000_0004) begin
      errors++; $display("FAIL zr_paddr got=%h exp=10000004", paddr); end
    checks++; if ({pwrite, pstrb} !== 5'b0) begin
      errors++; $display("FAIL zr_pwrite_pstrb got=%b exp=00000", {pwrite, pstrb}); end
    step();
    checks++; if ({psel, penable, rsp_valid} !== 3'b110) begin
      errors++; $display("FAIL zr_access got=%b exp=110", {psel, penable, rsp_valid}); end
    step();
    checks++; if ({rsp_valid, psel, penable} !== 3'b100) begin
      errors++; $display("FAIL zr_rsp_valid got=%b exp=100", {rsp_valid, psel, penable}); end
    checks++; if ({rsp_rdata, rsp_err, rsp_timeout} !== {32'hA5A5_1234, 2'b00}) begin
      errors++; $display("FAIL zr_rsp got=%h/%b%b exp=a5a51234/00", rsp_rdata, rsp_err, rsp_timeout); end
    step();
    checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL zr_idle got=%b exp=01", {rsp_valid, cmd_ready}); end
    checks++; if (paddr !== 32'h1000_0004) begin
      errors++; $display("FAIL zr_paddr_hold got=%h exp=10000004", paddr); end
  endtask

  task automatic test_wait_write();
    pready = 1'b0; prdata = 32'h5555_AAAA; pslverr = 1'b0; rsp_ready = 1'b1;
    issue(32'h2000_0010, 1'b1, 32'hCAFE_F00D, 4'b0011);
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 5) pready = 1'b1;
      checks++; if ({psel, penable, pwrite, pwdata, pstrb, rsp_valid} !== {3'b111, 32'hCAFE_F00D, 4'b0011, 1'b0}) begin
        errors++; $display("FAIL ww_access%0d got=%b%b%b/%h/%b/%b exp=111/cafef00d/0011/0",
                           i, psel, penable, pwrite, pwdata, pstrb, rsp_valid); end
    end
    step();
    pready = 1'b0;
    checks++; if ({rsp_valid, rsp_err, rsp_timeout, psel} !== 4'b1000) begin
      errors++; $display("FAIL ww_rsp_flags got=%b exp=1000", {rsp_valid, rsp_err, rsp_timeout, psel}); end
    checks++; if (rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL ww_rsp_rdata got=%h exp=00000000", rsp_rdata); end
    step();
  endtask

  task automatic test_slave_error();
    pready = 1'b1; pslverr = 1'b1; prdata = 32'h1111_2222; rsp_ready = 1'b1;
    issue(32'h0000_0300, 1'b0, 32'h0, 4'h0);
    step();
    step();
    checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110) begin
      errors++; $display("FAIL se_flags got=%b exp=110", {rsp_valid, rsp_err, rsp_timeout}); end
    checks++; if (rsp_rdata !== 32'h1111_2222) begin
      errors++; $display("FAIL se_rdata got=%h exp=11112222", rsp_rdata); end
    pslverr = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    pready = 1'b1; pslverr = 1'b0; prdata = 32'h0BAD_0BAD; rsp_ready = 1'b0;
    issue(32'h0000_0020, 1'b1, 32'h1234_5678, 4'hF);
    step();
    step();
    cmd_valid = 1'b1; cmd_addr = 32'h0000_0044; cmd_write = 1'b0; cmd_wdata = '0; cmd_wstrb = 4'hF;
    prdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL bb_cmd_ready_held got=%b exp=0", cmd_ready); end
    for (int i = 0; i < 4; i++) begin
      checks++; if ({rsp_valid, rsp_err, psel, rsp_rdata} !== {3'b100, 32'h0}) begin
        errors++; $display("FAIL bb_rsp1_hold%0d got=%b%b%b/%h exp=100/00000000",
                           i, rsp_valid, rsp_err, psel, rsp_rdata); end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if ({cmd_ready, rsp_valid, psel} !== 3'b110) begin
      errors++; $display("FAIL bb_handshake got=%b exp=110", {cmd_ready, rsp_valid, psel}); end
    step();
    cmd_valid = 1'b0;
    checks++; if ({psel, penable, rsp_valid, pwrite} !== 4'b1000) begin
      errors++; $display("FAIL bb_psel2 got=%b exp=1000", {psel, penable, rsp_valid, pwrite}); end
    checks++; if ({paddr, pstrb} !== {32'h0000_0044, 4'h0}) begin
      errors++; $display("FAIL bb_paddr2 got=%h/%h exp=00000044/0", paddr, pstrb); end
    step();
    checks++; if ({psel, penable} !== 2'b11) begin
      errors++; $display("FAIL bb_access2 got=%b exp=11", {psel, penable}); end
    step();
    checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL bb_rsp2 got=%b/%h exp=1/deadbeef", rsp_valid, rsp_rdata); end
    step();
  endtask

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  task automatic test_watchdog();
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h9999_9999; rsp_ready = 1'b1;
    issue(32'h0000_0080, 1'b0, 32'h0, 4'h0);
    repeat (8) step();
    checks++; if ({psel, penable, rsp_valid} !== 3'b110) begin
      errors++; $display("FAIL wd_last_access got=%b exp=110", {psel, penable, rsp_valid}); end
    step();
    checks++; if ({psel, penable, rsp_valid, rsp_err, rsp_timeout} !== 5'b00111) begin
      errors++; $display("FAIL wd_abort got=%b exp=00111", {psel, penable, rsp_valid, rsp_err, rsp_timeout}); end
    checks++; if (rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL wd_rdata got=%h exp=00000000", rsp_rdata); end
    step();
    issue(32'h0000_0084, 1'b0, 32'h0, 4'h0);
    repeat (8) step();
    pready = 1'b1;
    checks++; if ({psel, penable, rsp_valid} !== 3'b110) begin
      errors++; $display("FAIL wd_race_access got=%b exp=110", {psel, penable, rsp_valid}); end
    step();
    pready = 1'b0;
    checks++; if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b100, 32'h9999_9999}) begin
      errors++; $display("FAIL wd_race_rsp got=%b%b%b/%h exp=100/99999999",
                         rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
    step();
  endtask
`else
  task automatic test_long_wait();
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h7777_0000; rsp_ready = 1'b1;
    issue(32'h0000_0050, 1'b0, 32'h0, 4'h0);
    repeat (30) step();
    checks++; if ({psel, penable, rsp_valid, rsp_timeout} !== 4'b1100) begin
      errors++; $display("FAIL lw_still_access got=%b exp=1100", {psel, penable, rsp_valid, rsp_timeout}); end
    pready = 1'b1;
    step();
    pready = 1'b0;
    checks++; if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b100, 32'h7777_0000}) begin
      errors++; $display("FAIL lw_rsp got=%b%b%b/%h exp=100/77770000",
                         rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
    step();
  endtask
`endif

  task automatic test_reset_mid();
    pready = 1'b0; pslverr = 1'b0; rsp_ready = 1'b1;
    issue(32'h0000_0060, 1'b0, 32'h0, 4'h0);
    step();
    checks++; if ({psel, penable} !== 2'b11) begin
      errors++; $display("FAIL rm_in_access got=%b exp=11", {psel, penable}); end
    presetn = 1'b0;
    #1;
    checks++; if ({psel, penable, rsp_valid} !== 3'b000) begin
      errors++; $display("FAIL rm_async_drop got=%b exp=000", {psel, penable, rsp_valid}); end
    repeat (2) step();
    presetn = 1'b1;
    step();
    step();
    checks++; if ({rsp_valid, psel, cmd_ready} !== 3'b001) begin
      errors++; $display("FAIL rm_after_release got=%b exp=001", {rsp_valid, psel, cmd_ready}); end
    pready = 1'b1; prdata = 32'h600D_F00D;
    issue(32'h0000_0064, 1'b0, 32'h0, 4'h0);
    step();
    step();
    checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h600D_F00D}) begin
      errors++; $display("FAIL rm_next_cmd got=%b%b/%h exp=10/600df00d", rsp_valid, rsp_err, rsp_rdata); end
    step();
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_wait_write();
    test_slave_error();
    test_back_to_back();
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    test_watchdog();
`else
    test_long_wait();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

Initiator-side APB block that turns a simple valid/ready command stream into single APB4 transfers on the peripheral bus. It returns each completion on a valid/ready response channel. It lets non-CPU agents in the SoC (boot loader, debug or DMA logic) reach the SPI flash, UART and GPIO slaves through the existing APB fabric. It has one transfer outstanding and an optional hung-slave watchdog.

## Interface
- ADDR_W, default `P_ADDR_W (32): paddr / cmd_addr width
- DATA_W, default `P_DATA_W (32): data width
- STRB_W, default `P_STRB_W (DATA_W/8): strobe width
- TIMEOUT_CYCLES, default 1024: number of ACCESS cycles before abort; only used with the watchdog compiled in; legal range 2..65535

Ports:
- pclk  in  1  bus clock; all logic is in this one domain
- presetn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_addr  in  ADDR_W  byte address
- cmd_write  in  1  1 = write, 0 = read
- cmd_wdata  in  DATA_W  write data
- cmd_wstrb  in  STRB_W  write byte lanes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
- rsp_err  out  1  pslverr or timeout
- rsp_timeout  out  1  response was produced by the watchdog
- paddr, psel, penable, pwrite, pwdata, pstrb  out  APB4 request signals
- pready, prdata, pslverr  in  APB4 completion signals

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- cmd_ready = (state==IDLE) | (state==RESP & rsp_ready).
- On acceptance, the command is registered and the next state is SETUP.
- Address handling: paddr = {cmd_addr[ADDR_W-1:2], 2'b00}.
- Write data: pwdata = cmd_wdata.
- Strobes: pstrb = cmd_wstrb for writes; pstrb is forced to 0 for reads.
- SETUP: psel=1, penable=0 for exactly one cycle, then the state moves to ACCESS.
- ACCESS: psel=1, penable=1. paddr, pwrite, pwdata and pstrb stay stable until completion.
- On pready=1 in ACCESS:
  - rsp_rdata = cmd_write ? 0 : prdata
  - rsp_err = pslverr
  - rsp_timeout = 0
  - the state moves to RESP
- RESP: rsp_valid=1 and the response fields are held until rsp_ready.
  - If rsp_ready=1 with no new command, the state goes to IDLE.
  - If rsp_ready=1 and cmd_valid=1 in the same cycle, the new command is accepted and the state goes straight to SETUP (back-to-back).
- Between transfers psel=0 and penable=0. paddr, pwrite, pwdata and pstrb keep their last values.
- pslverr is sampled only when pready=1. prdata is ignored on writes.

## Timing
- Reset values: every output is 0, state = IDLE. cmd_ready becomes 1 on the first cycle after reset deassertion.
- Accept edge T: psel rises at T+1 and penable rises at T+2.
- With pready=1 at T+2, rsp_valid=1 at T+3. Minimum command-to-response latency is 3 cycles.
- Each wait state adds 1 cycle.
- Back-to-back throughput is one transfer per 3 cycles (SETUP, ACCESS, RESP/accept).
- cmd_ready is combinational from rsp_ready only in the RESP state. All APB outputs are registered.
- presetn asserted mid-transfer: psel and penable drop immediately (asynchronously), the transfer is lost and no response is produced.

## Configuration
- APB_CMD_MASTER_TIMEOUT_EN defined:
  - A 16-bit counter clears on entering ACCESS and increments on every ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT_CYCLES-1 with pready still 0, the transfer is aborted: psel and penable go to 0 on the next cycle and the state moves to RESP.
  - The aborted response has rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - pready arriving in the same cycle as the limit wins, and the transfer completes normally.
- Not defined: ACCESS waits indefinitely, the counter is not built, and rsp_timeout is tied to 0.

## Structure
- Shared package apb_cmd_pkg:
  - state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3)
  - the width localparam for the timeout counter (16)
- Width macros stay in amba_define.v.
- One sub-module, apb_cmd_wdog, holds the timeout counter with inputs start, busy, pready and output expire. It is instantiated only under APB_CMD_MASTER_TIMEOUT_EN.

## Test plan
- Zero-wait read: read command, addr 0x1000_0007, with pready=1 and prdata=0xA5A5_1234 on the first ACCESS cycle -> paddr=0x1000_0004, pstrb=0, rsp_valid at T+3, rsp_rdata=0xA5A5_1234, rsp_err=0.
- Wait-state write: write command, wdata=0xCAFE_F00D, wstrb=4'b0011, pready delayed 5 cycles -> pwdata and pstrb stable through every ACCESS cycle, response at T+8 with rsp_rdata=0 and rsp_err=0.
- Slave error: read with pslverr=1 and pready=1 -> rsp_err=1, rsp_timeout=0.
- Back-to-back with backpressure: two commands with rsp_ready held 0 for 4 cycles -> response 1 stays stable; the second psel rises exactly 1 cycle after the rsp_ready handshake.
- Watchdog (macro on, TIMEOUT_CYCLES=8): pready never asserted -> psel drops after 8 ACCESS cycles, response has rsp_err=1, rsp_timeout=1, rsp_rdata=0. Repeat with pready arriving on the 8th cycle -> normal completion, rsp_timeout=0.
- Reset mid-ACCESS: drop presetn -> psel, penable and rsp_valid go to 0 immediately; after release the state is IDLE and the next command completes normally.
